// File: rtl/param_up_down_counter.sv
// Synchronous WIDTH-bit up/down counter modulo MOD, with parallel load, terminal count and a registered wrap pulse.
// Optional macro PARAM_UP_DOWN_COUNTER_SATURATE_EN makes the counter saturate at its ends instead of wrapping.
module param_up_down_counter #(
    parameter int              WIDTH = 8,
    parameter longint unsigned MOD   = 64'd1 << WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             t,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] qout,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] TOP     = WIDTH'(MOD - 64'd1);
    localparam logic [WIDTH:0]   TOP_EXT = {1'b0, TOP};
    localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);

    logic [WIDTH:0]   step_ext;
    logic             crossing;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;

`ifdef PARAM_UP_DOWN_COUNTER_SATURATE_EN
    logic sat_run;
    logic sat_run_next;
`endif

    // The extra bit exposes the borrow below 0; overflow past TOP is a plain compare.
    always_comb begin
        step_ext = mode ? ({1'b0, qout} - ONE_EXT) : ({1'b0, qout} + ONE_EXT);
        crossing = mode ? step_ext[WIDTH] : (step_ext > TOP_EXT);
        tc       = t & (mode ? (qout == '0) : (qout == TOP));
    end

    always_comb begin
        q_next    = qout;
        wrap_next = 1'b0;
`ifdef PARAM_UP_DOWN_COUNTER_SATURATE_EN
        sat_run_next = sat_run;
`endif
        if (load) begin
            q_next = (din > TOP) ? TOP : din;
`ifdef PARAM_UP_DOWN_COUNTER_SATURATE_EN
            sat_run_next = 1'b0;
`endif
        end else if (t) begin
`ifdef PARAM_UP_DOWN_COUNTER_SATURATE_EN
            sat_run_next = crossing;
            if (crossing) begin
                wrap_next = ~sat_run;
            end else begin
                q_next = step_ext[WIDTH-1:0];
            end
`else
            if (crossing) begin
                q_next    = mode ? TOP : '0;
                wrap_next = 1'b1;
            end else begin
                q_next = step_ext[WIDTH-1:0];
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qout <= '0;
            wrap <= 1'b0;
        end else begin
            qout <= q_next;
            wrap <= wrap_next;
        end
    end

`ifdef PARAM_UP_DOWN_COUNTER_SATURATE_EN
    // Remembers whether the last enabled edge already pushed against a limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_run <= 1'b0;
        end else begin
            sat_run <= sat_run_next;
        end
    end
`endif

endmodule

// File: tb/tb_param_up_down_counter.sv
// Self-checking bench for param_up_down_counter (WIDTH=4, MOD=10, wrap-around build):
// directed vector table, async-reset sequences, then randomized traffic against an arithmetic model.
module tb_param_up_down_counter;

    localparam int              WIDTH = 4;
    localparam longint unsigned MOD   = 10;
    localparam int              MODI  = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             t;
    logic             mode;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] qout;
    logic             tc;
    logic             wrap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       ld;
        logic       en;
        logic       dn;
        logic [3:0] d;
        int         exp_q;
        logic       exp_tc;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[$];

    param_up_down_counter #(.WIDTH(WIDTH), .MOD(MOD)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .t    (t),
        .mode (mode),
        .load (load),
        .din  (din),
        .qout (qout),
        .tc   (tc),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic ld, input logic en, input logic dn, input int d,
                                input int q, input logic etc, input logic ew);
        vec_t v;
        v.ld = ld; v.en = en; v.dn = dn; v.d = 4'(d);
        v.exp_q = q; v.exp_tc = etc; v.exp_wrap = ew;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive inputs on the falling edge, then return just after the following rising edge.
    task automatic applyStimulus(input logic ld, input logic en, input logic dn, input logic [3:0] d);
        @(negedge clk);
        load = ld; t = en; mode = dn; din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int mq;
        int mw;
        int etc;

        rst_n = 1'b0; t = 1'b0; mode = 1'b0; load = 1'b0; din = '0;
        #2;
        checkOutput("reset qout", int'(qout), 0);
        checkOutput("reset wrap", int'(wrap), 0);
        checkOutput("reset tc", int'(tc), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Up count from 0 through the wrap at 9.
        for (int i = 1; i <= 12; i++)
            vecs.push_back(mk(0, 1, 0, 0, i % MODI, (i == 9), (i == 10)));
        // Down from 2 across 0.
        vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 9, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 8, 0, 0));
        // Load wins over t; out-of-range loads clamp.
        vecs.push_back(mk(1, 1, 0, 7, 7, 0, 0));
        vecs.push_back(mk(1, 1, 1, 13, 9, 0, 0));
        vecs.push_back(mk(1, 0, 0, 4, 4, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, i[0], 0, 4, 0, 0));
        // Direction reversal mid-stream.
        vecs.push_back(mk(0, 1, 0, 0, 5, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 5, 0, 0));
        // Load clears a pending wrap pulse.
        vecs.push_back(mk(1, 0, 0, 9, 9, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 1, 15, 9, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 9, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 9, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].ld, vecs[i].en, vecs[i].dn, vecs[i].d);
            checkOutput($sformatf("vec%0d qout", i), int'(qout), vecs[i].exp_q);
            checkOutput($sformatf("vec%0d tc", i), int'(tc), int'(vecs[i].exp_tc));
            checkOutput($sformatf("vec%0d wrap", i), int'(wrap), int'(vecs[i].exp_wrap));
        end

        // Asynchronous reset mid-cycle at qout=6.
        applyStimulus(1, 0, 0, 4'd5);
        applyStimulus(0, 1, 0, 4'd0);
        checkOutput("pre-reset qout", int'(qout), 6);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset qout", int'(qout), 0);
        checkOutput("async reset wrap", int'(wrap), 0);

        // Reset held across an enabled edge keeps the count at 0.
        @(posedge clk);
        #1;
        checkOutput("held reset qout", int'(qout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("restart qout", int'(qout), 1);

        // Reset during a wrap pulse kills the pulse immediately.
        applyStimulus(1, 0, 0, 4'd9);
        applyStimulus(0, 1, 0, 4'd0);
        checkOutput("wrap before reset", int'(wrap), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("wrap after reset", int'(wrap), 0);
        checkOutput("qout after reset", int'(qout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        load = 1'b0; t = 1'b0;

        // Randomized traffic against a modular-arithmetic model.
        mq = 0;
        mw = 0;
        for (int i = 0; i < 400; i++) begin
            logic       r_ld;
            logic       r_en;
            logic       r_dn;
            logic [3:0] r_d;
            r_ld = ($urandom_range(0, 7) == 0);
            r_en = ($urandom_range(0, 3) != 0);
            r_dn = ($urandom_range(0, 2) == 0);
            r_d  = 4'($urandom_range(0, 15));
            if (r_ld) begin
                mq = (int'(r_d) > MODI - 1) ? MODI - 1 : int'(r_d);
                mw = 0;
            end else if (r_en) begin
                if (!r_dn) begin
                    mw = (mq == MODI - 1) ? 1 : 0;
                    mq = (mq + 1) % MODI;
                end else begin
                    mw = (mq == 0) ? 1 : 0;
                    mq = (mq + MODI - 1) % MODI;
                end
            end else begin
                mw = 0;
            end
            etc = (r_en && ((r_dn && mq == 0) || (!r_dn && mq == MODI - 1))) ? 1 : 0;
            applyStimulus(r_ld, r_en, r_dn, r_d);
            checkOutput($sformatf("rand%0d qout", i), int'(qout), mq);
            checkOutput($sformatf("rand%0d wrap", i), int'(wrap), mw);
            checkOutput($sformatf("rand%0d tc", i), int'(tc), etc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
